a2d_round_robin: RTL and testbench

- Sequences the shared SPI A2D converter so that the load-cell and analog datapath stays fed. The consumers are the rider-detect/steer-enable logic, the steering and the battery monitor.
- On each `nxt` request, performs one complete round of four conversions in fixed order: left load cell, right load cell, steer pot, battery.
- Each conversion is two SPI transactions: a command, then a read. The block drives the SPI master's `wrt`/`cmd` handshake and latches each 12-bit result into a per-channel holding register.

---
 rtl/a2d_round_robin.sv | 125 ++++++++++++
 tb/tb_a2d_round_robin.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a2d_round_robin.sv
// Round-robin sequencer for the shared SPI A2D: each nxt request runs one round of
// command/read transaction pairs over left load, right load, steer pot and battery.
module a2d_round_robin #(
    parameter logic [2:0] LFT_CH   = 3'd0,
    parameter logic [2:0] RGHT_CH  = 3'd4,
    parameter logic [2:0] STEER_CH = 3'd5,
    parameter logic [2:0] BATT_CH  = 3'd6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        busy,
    output logic        round_done
);

    typedef enum logic [1:0] {IDLE, CMD_WAIT, GAP, RD_WAIT} state_t;

    state_t      state_q;
    logic [1:0]  idx_q;
    logic [1:0]  idx_d;
    logic        wrt_q;
    logic [15:0] cmd_q;
    logic [11:0] lft_q;
    logic [11:0] rght_q;
    logic [11:0] steer_q;
    logic [11:0] batt_q;
    logic        busy_q;
    logic        round_done_q;
    logic [3:0]  unusedRdHi;

    assign idx_d      = idx_q + 2'd1;
    assign unusedRdHi = rd_data[15:12];

    function automatic logic [15:0] cmdFor(input logic [1:0] idx);
        logic [2:0] ch;
        ch = LFT_CH;
        case (idx)
            2'd0: ch = LFT_CH;
            2'd1: ch = RGHT_CH;
            2'd2: ch = STEER_CH;
            2'd3: ch = BATT_CH;
            default: ch = LFT_CH;
        endcase
        return {2'b00, ch, 11'h000};
    endfunction

    // A done coinciding with our own wrt pulse cannot belong to that transaction, so it is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= 2'd0;
            wrt_q        <= 1'b0;
            cmd_q        <= 16'h0000;
            lft_q        <= 12'h000;
            rght_q       <= 12'h000;
            steer_q      <= 12'h000;
            batt_q       <= 12'h000;
            busy_q       <= 1'b0;
            round_done_q <= 1'b0;
        end else begin
            wrt_q        <= 1'b0;
            round_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (nxt) begin
                        idx_q   <= 2'd0;
                        wrt_q   <= 1'b1;
                        cmd_q   <= cmdFor(2'd0);
                        busy_q  <= 1'b1;
                        state_q <= CMD_WAIT;
                    end
                end
                CMD_WAIT: begin
                    if (done && !wrt_q) begin
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    wrt_q   <= 1'b1;
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (done && !wrt_q) begin
                        case (idx_q)
                            2'd0: lft_q   <= rd_data[11:0];
                            2'd1: rght_q  <= rd_data[11:0];
                            2'd2: steer_q <= rd_data[11:0];
                            default: batt_q <= rd_data[11:0];
                        endcase
                        if (idx_q == 2'd3) begin
                            idx_q        <= 2'd0;
                            busy_q       <= 1'b0;
                            round_done_q <= 1'b1;
                            state_q      <= IDLE;
                        end else begin
                            idx_q   <= idx_d;
                            wrt_q   <= 1'b1;
                            cmd_q   <= cmdFor(idx_d);
                            state_q <= CMD_WAIT;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wrt        = wrt_q;
    assign cmd        = cmd_q;
    assign lft_ld     = lft_q;
    assign rght_ld    = rght_q;
    assign steer_pot  = steer_q;
    assign batt       = batt_q;
    assign busy       = busy_q;
    assign round_done = round_done_q;

endmodule

// File: tb/tb_a2d_round_robin.sv
// Bench for a2d_round_robin: a transaction-level reference model checked every cycle,
// an SPI responder with programmable latency, and directed scenarios with literal expectations.
module tb_a2d_round_robin;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nxt = 1'b0;
    logic        spiDone = 1'b0;
    logic        forceDone = 1'b0;
    logic        done;
    logic [15:0] rdData = 16'h0000;
    logic        wrt;
    logic [15:0] cmd;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic [11:0] steer_pot;
    logic [11:0] batt;
    logic        busy;
    logic        round_done;

    assign done = spiDone | forceDone;

    a2d_round_robin dut (
        .clk(clk), .rst_n(rst_n), .nxt(nxt), .done(done), .rd_data(rdData),
        .wrt(wrt), .cmd(cmd), .lft_ld(lft_ld), .rght_ld(rght_ld),
        .steer_pot(steer_pot), .batt(batt), .busy(busy), .round_done(round_done)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          nxtEdge = 0;
    int          kDelay = 20;
    bit          dblDone = 1'b0;
    logic [15:0] rdVals[4];
    int          wrtCount = 0;
    int          rdCount = 0;
    logic [15:0] cmdLog[$];

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // SPI responder: done K cycles after each wrt; command dones can optionally be stretched into GAP.
    function automatic int chanIndex(input logic [2:0] ch);
        case (ch)
            3'd4: return 1;
            3'd5: return 2;
            3'd6: return 3;
            default: return 0;
        endcase
    endfunction

    initial begin
        int  cnt = 0;
        int  spiTxn = 0;
        bit  curRead = 1'b0;
        bit  extra = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                spiDone = 1'b0; cnt = 0; extra = 1'b0; spiTxn = 0;
            end else begin
                spiDone = 1'b0;
                if (extra) begin spiDone = 1'b1; extra = 1'b0; end
                if (cnt == 1) begin
                    spiDone = 1'b1;
                    cnt = 0;
                    if (curRead) rdData = rdVals[chanIndex(cmd[13:11])];
                    else if (dblDone) extra = 1'b1;
                end else if (cnt > 1) begin
                    cnt--;
                end
                if (wrt) begin
                    curRead = spiTxn[0];
                    spiTxn++;
                    cnt = kDelay;
                end
                if (round_done) spiTxn = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (wrt) begin wrtCount++; cmdLog.push_back(cmd); end
        if (round_done) rdCount++;
    end

    // Reference model: a round is eight transactions; even ones are commands, odd ones reads.
    int          chList[4] = '{0, 4, 5, 6};
    logic        mWrt = 1'b0;
    logic [15:0] mCmd = 16'h0000;
    logic        mBusy = 1'b0;
    logic        mRd = 1'b0;
    logic [11:0] mReg[4] = '{12'h0, 12'h0, 12'h0, 12'h0};
    int          mTxn = 0;
    bit          mGap = 1'b0;

    initial forever begin
        bit wasWrt;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mWrt = 1'b0; mCmd = 16'h0000; mBusy = 1'b0; mRd = 1'b0;
            for (int i = 0; i < 4; i++) mReg[i] = 12'h000;
            mTxn = 0; mGap = 1'b0;
        end else begin
            wasWrt = mWrt;
            mWrt = 1'b0;
            mRd = 1'b0;
            if (!mBusy) begin
                if (nxt) begin
                    mBusy = 1'b1; mTxn = 0; mWrt = 1'b1; mCmd = 16'(chList[0] * 2048);
                end
            end else if (mGap) begin
                mGap = 1'b0; mTxn++; mWrt = 1'b1;
            end else if (done && !wasWrt) begin
                if (mTxn % 2 == 0) begin
                    mGap = 1'b1;
                end else begin
                    mReg[mTxn / 2] = rdData[11:0];
                    if (mTxn == 7) begin
                        mBusy = 1'b0; mRd = 1'b1;
                    end else begin
                        mTxn++; mWrt = 1'b1; mCmd = 16'(chList[mTxn / 2] * 2048);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [66:0] act, input logic [66:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic compareLoop();
        forever begin
            @(negedge clk);
            checkOutput("cycle",
                {wrt, cmd, busy, round_done, lft_ld, rght_ld, steer_pot, batt},
                {mWrt, mCmd, mBusy, mRd, mReg[0], mReg[1], mReg[2], mReg[3]});
        end
    endtask

    task automatic applyStimulus(input int k, input logic [15:0] v0, input logic [15:0] v1,
                                 input logic [15:0] v2, input logic [15:0] v3);
        kDelay = k;
        rdVals[0] = v0; rdVals[1] = v1; rdVals[2] = v2; rdVals[3] = v3;
        @(negedge clk);
        nxt = 1'b1;
        nxtEdge = cyc + 1;
        @(negedge clk);
        nxt = 1'b0;
    endtask

    task automatic waitRoundDone(input string tag, input int maxCyc);
        int n = 0;
        do begin @(negedge clk); n++; end while (!round_done && n < maxCyc);
        checkOutput({tag, "_round_done"}, 67'(round_done), 67'd1);
    endtask

    task automatic checkReadings(input string tag, input logic [47:0] exp);
        checkOutput(tag, 67'({lft_ld, rght_ld, steer_pot, batt}), 67'(exp));
    endtask

    initial begin
        int          base;
        int          w0;
        int          r0;
        int          n;
        int          seen;
        int          rdCyc;
        logic [15:0] expCmds[8];
        logic [15:0] act;

        repeat (3) @(negedge clk);
        checkOutput("reset", {wrt, cmd, busy, round_done, lft_ld, rght_ld, steer_pot, batt}, 67'd0);
        rst_n = 1'b1;
        fork compareLoop(); join_none

        $display("[TB] round with K=20");
        base = cmdLog.size(); r0 = rdCount;
        applyStimulus(20, 16'h01A6, 16'h01A0, 16'h07FF, 16'h0C00);
        waitRoundDone("k20", 300);
        repeat (3) @(negedge clk);
        expCmds = '{16'h0000, 16'h0000, 16'h2000, 16'h2000, 16'h2800, 16'h2800, 16'h3000, 16'h3000};
        for (int i = 0; i < 8; i++) begin
            act = (base + i < cmdLog.size()) ? cmdLog[base + i] : 16'hFFFF;
            checkOutput($sformatf("cmd%0d", i), 67'(act), 67'(expCmds[i]));
        end
        checkReadings("k20_readings", {12'h1A6, 12'h1A0, 12'h7FF, 12'hC00});
        checkOutput("k20_rd_pulses", 67'(rdCount - r0), 67'd1);
        checkOutput("k20_busy_after", 67'(busy), 67'd0);

        $display("[TB] upper bits masked");
        applyStimulus(3, 16'hF2A8, 16'h5123, 16'hA456, 16'hF789);
        waitRoundDone("mask", 100);
        @(negedge clk);
        checkReadings("mask_readings", {12'h2A8, 12'h123, 12'h456, 12'h789});

        $display("[TB] nxt pulsed mid-round");
        w0 = wrtCount; r0 = rdCount; n = 0;
        applyStimulus(4, 16'h0321, 16'h0654, 16'h0987, 16'h0CBA);
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (round_done) begin nxt = 1'b0; break; end
            nxt = (n % 3 == 0);
        end
        nxt = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("midnxt_wrts", 67'(wrtCount - w0), 67'd8);
        checkOutput("midnxt_rounds", 67'(rdCount - r0), 67'd1);

        $display("[TB] nxt held high");
        kDelay = 2;
        @(negedge clk);
        nxt = 1'b1;
        waitRoundDone("held1", 100);
        rdCyc = cyc; n = 0;
        do begin @(negedge clk); n++; end while (!wrt && n < 5);
        checkOutput("held_restart_gap", 67'(cyc - rdCyc), 67'd1);
        nxt = 1'b0;
        waitRoundDone("held2", 100);

        $display("[TB] spurious done in IDLE and GAP");
        repeat (3) @(negedge clk);
        w0 = wrtCount;
        forceDone = 1'b1;
        @(negedge clk);
        forceDone = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("idle_done_wrts", 67'(wrtCount - w0), 67'd0);
        checkReadings("idle_done_readings", {12'h321, 12'h654, 12'h987, 12'hCBA});
        dblDone = 1'b1;
        w0 = wrtCount;
        applyStimulus(4, 16'h0111, 16'h0222, 16'h0333, 16'h0444);
        waitRoundDone("gap", 200);
        dblDone = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("gap_done_wrts", 67'(wrtCount - w0), 67'd8);
        checkReadings("gap_readings", {12'h111, 12'h222, 12'h333, 12'h444});

        $display("[TB] reset during steer read");
        applyStimulus(20, 16'h0EEE, 16'h0DDD, 16'h0CCC, 16'h0BBB);
        seen = 0; n = 0;
        while (seen < 2 && n < 400) begin
            @(negedge clk);
            n++;
            if (wrt && cmd == 16'h2800) seen++;
        end
        checkOutput("steer_read_reached", 67'(seen), 67'd2);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset", {wrt, cmd, busy, round_done, lft_ld, rght_ld, steer_pot, batt}, 67'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] restart after reset with K=1");
        base = cmdLog.size();
        applyStimulus(1, 16'h0AAA, 16'h0BBB, 16'h0CCC, 16'h0DDD);
        waitRoundDone("k1", 40);
        checkOutput("k1_latency", 67'(cyc - nxtEdge), 67'd20);
        act = (base < cmdLog.size()) ? cmdLog[base] : 16'hFFFF;
        checkOutput("restart_cmd", 67'(act), 67'h0000);
        @(negedge clk);
        checkReadings("k1_readings", {12'hAAA, 12'hBBB, 12'hCCC, 12'hDDD});

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
